counter_arb_seq: RTL and testbench



---
 rtl/counter_arb_seq.sv | 151 +++++++++++++++
 tb/tb_counter_arb_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/counter_arb_seq.sv
// Two-requester round-robin controller for a loadable up/down counter run.
// Optional macro COUNTER_ARB_NOWRAP_EN rejects wrapping commands with an err pulse.
module counter_arb_seq #(
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [CNT_WIDTH-1:0] a_start,
  input  logic [CNT_WIDTH-1:0] a_target,
  input  logic                 a_up_down,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [CNT_WIDTH-1:0] b_start,
  input  logic [CNT_WIDTH-1:0] b_target,
  input  logic                 b_up_down,
  output logic [CNT_WIDTH-1:0] count_out,
  output logic                 busy,
  output logic                 done,
  output logic                 done_id,
  output logic                 err,
  output logic                 err_id,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] target_q;
  logic                 up_q;
  logic                 id_q;
  logic                 last_grant_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 done_id_q;

  logic                 grant_a;
  logic                 grant_b;
  logic                 accept;
  logic [CNT_WIDTH-1:0] sel_start;
  logic [CNT_WIDTH-1:0] sel_target;
  logic                 sel_up;
  logic [CNT_WIDTH-1:0] count_d;

  // Handshake: a command transfers on a rising edge where valid and ready are
  // both high; ready is combinational from valid/state and only rises in IDLE.
  always_comb begin
    grant_a    = a_valid & (~b_valid | last_grant_q);
    grant_b    = b_valid & (~a_valid | ~last_grant_q);
    accept     = (state_q == IDLE) & (grant_a | grant_b);
    sel_start  = grant_b ? b_start   : a_start;
    sel_target = grant_b ? b_target  : a_target;
    sel_up     = grant_b ? b_up_down : a_up_down;
    count_d    = up_q ? count_q + CNT_WIDTH'(1) : count_q - CNT_WIDTH'(1);
  end

  assign a_ready   = (state_q == IDLE) & grant_a;
  assign b_ready   = (state_q == IDLE) & grant_b;
  assign count_out = count_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign state_dbg = state_q;

`ifdef COUNTER_ARB_NOWRAP_EN
  logic err_q;
  logic err_id_q;
  logic wrap;

  // A wrapping command would pass through the modulo boundary on its way.
  assign wrap   = sel_up ? (sel_target < sel_start) : (sel_target > sel_start);
  assign err    = err_q;
  assign err_id = err_id_q;
`else
  assign err    = 1'b0;
  assign err_id = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      target_q     <= '0;
      up_q         <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_id_q    <= 1'b0;
`ifdef COUNTER_ARB_NOWRAP_EN
      err_q        <= 1'b0;
      err_id_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef COUNTER_ARB_NOWRAP_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (accept) begin
            last_grant_q <= grant_b;
`ifdef COUNTER_ARB_NOWRAP_EN
            if (wrap) begin
              err_q    <= 1'b1;
              err_id_q <= grant_b;
            end else
`endif
            begin
              count_q  <= sel_start;
              target_q <= sel_target;
              up_q     <= sel_up;
              id_q     <= grant_b;
              busy_q   <= 1'b1;
              if (sel_start == sel_target) begin
                state_q   <= DONE;
                done_q    <= 1'b1;
                done_id_q <= grant_b;
              end else begin
                state_q <= RUN;
              end
            end
          end
        end
        RUN: begin
          count_q <= count_d;
          if (count_d == target_q) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            done_id_q <= id_q;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_arb_seq.sv
// Bench for counter_arb_seq: directed test-plan runs, then random traffic,
// all compared against a step-count reference model of a counter run.
module tb_counter_arb_seq;

  localparam int W    = 3;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         a_valid, b_valid;
  logic         a_ready, b_ready;
  logic [W-1:0] a_start, a_target, b_start, b_target;
  logic         a_up_down, b_up_down;
  logic [W-1:0] count_out;
  logic         busy, done, done_id, err, err_id;
  logic [1:0]   state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: a run is (start, direction, distance n) and k steps taken
  bit           m_active;
  int           m_k, m_n;
  logic [W-1:0] m_start, m_count;
  bit           m_up, m_id, m_last;
  bit           m_err, m_err_id;
  bit           m_reset_edge;
  bit           a_acc, b_acc;
  bit           ga, gb;

  counter_arb_seq #(.CNT_WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_start(a_start),
    .a_target(a_target), .a_up_down(a_up_down),
    .b_valid(b_valid), .b_ready(b_ready), .b_start(b_start),
    .b_target(b_target), .b_up_down(b_up_down),
    .count_out(count_out), .busy(busy), .done(done), .done_id(done_id),
    .err(err), .err_id(err_id), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] s, t;
    bit u, id;
    bit is_wrap;
    a_acc = 0; b_acc = 0; m_err = 0; m_reset_edge = 0;
    if (reset) begin
      m_active = 0; m_count = '0; m_last = 1; m_reset_edge = 1;
      return;
    end
    if (!m_active) begin
      if (ga || gb) begin
        id = gb;
        s  = gb ? b_start : a_start;
        t  = gb ? b_target : a_target;
        u  = gb ? b_up_down : a_up_down;
        a_acc = ga; b_acc = gb;
        m_last = id;
        is_wrap = u ? (t < s) : (t > s);
`ifdef COUNTER_ARB_NOWRAP_EN
        if (is_wrap) begin
          m_err = 1; m_err_id = id;
        end else begin
`else
        begin
`endif
          m_active = 1; m_k = 0; m_start = s; m_count = s; m_up = u; m_id = id;
          m_n = u ? ((int'(t) - int'(s)) & MASK) : ((int'(s) - int'(t)) & MASK);
        end
      end
    end else begin
      m_k++;
      if (m_k > m_n) m_active = 0;
      else m_count = W'(m_up ? ((int'(m_start) + m_k) & MASK)
                             : ((int'(m_start) - m_k) & MASK));
    end
  endtask

  // one clock: readies checked before the edge, outputs after; ends at negedge
  task automatic step_cycle();
    #1;
    ga = a_valid && (!b_valid || m_last);
    gb = b_valid && (!a_valid || !m_last);
    check("a_ready", a_ready, !m_active && ga);
    check("b_ready", b_ready, !m_active && gb);
    @(posedge clk);
    model_edge();
    #1;
    check("count_out", count_out, m_count);
    check("busy", busy, m_active);
    check("done", done, m_active && (m_k == m_n));
    if (m_active && (m_k == m_n)) check("done_id", done_id, m_id);
    check("err", err, m_err);
    if (m_err) check("err_id", err_id, m_err_id);
    if (m_reset_edge) begin
      check("rst_done_id", done_id, 0);
      check("rst_err_id", err_id, 0);
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (a_acc) begin a_valid = 0; a_acc = 0; end
      if (b_acc) begin b_valid = 0; b_acc = 0; end
      step_cycle();
    end
  endtask

  task automatic set_a(input int s, input int t, input bit u);
    if (a_acc) a_acc = 0;
    a_start = W'(s); a_target = W'(t); a_up_down = u; a_valid = 1;
  endtask

  task automatic set_b(input int s, input int t, input bit u);
    if (b_acc) b_acc = 0;
    b_start = W'(s); b_target = W'(t); b_up_down = u; b_valid = 1;
  endtask

  task automatic drive_random();
    if (a_acc) begin a_valid = 0; a_acc = 0; end
    if (b_acc) begin b_valid = 0; b_acc = 0; end
    if (!a_valid && $urandom_range(0, 2) == 0) begin
      a_start   = W'($urandom_range(0, MASK));
      a_target  = ($urandom_range(0, 3) == 0) ? a_start : W'($urandom_range(0, MASK));
      a_up_down = 1'($urandom_range(0, 1));
      a_valid   = 1;
    end
    if (!b_valid && $urandom_range(0, 2) == 0) begin
      b_start   = W'($urandom_range(0, MASK));
      b_target  = ($urandom_range(0, 3) == 0) ? b_start : W'($urandom_range(0, MASK));
      b_up_down = 1'($urandom_range(0, 1));
      b_valid   = 1;
    end
    reset = ($urandom_range(0, 80) == 0);
  endtask

  initial begin
    reset = 1; a_valid = 0; b_valid = 0;
    a_start = '0; a_target = '0; a_up_down = 0;
    b_start = '0; b_target = '0; b_up_down = 0;
    m_active = 0; m_k = 0; m_n = 0; m_start = '0; m_count = '0;
    m_up = 0; m_id = 0; m_last = 1; m_err = 0; m_err_id = 0;
    a_acc = 0; b_acc = 0;
    @(negedge clk);
    run(2);
    reset = 0;

    // A 2->5 up
    set_a(2, 5, 1);
    run(7);

    // A and B contend right after reset
    reset = 1;
    run(1);
    reset = 0;
    set_a(1, 3, 1);
    set_b(6, 4, 0);
    run(12);

    // B 6->1 up wraps (or is rejected with the nowrap build)
    set_b(6, 1, 1);
    run(7);

    // zero-distance run
    set_a(4, 4, 1);
    run(4);

    // reset mid-run with B waiting
    set_a(0, 7, 1);
    run(1);
    set_b(3, 5, 1);
    run(3);
    reset = 1;
    run(1);
    reset = 0;
    run(8);

    for (int i = 0; i < 3000; i++) begin
      drive_random();
      step_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
